// File: rtl/demux8_collect.sv
// Serial-to-parallel collector: steers accepted serial bits into an 8-lane shadow byte
// and hands completed bytes to a single-entry holding register with a valid/ready handshake.
module demux8_collect #(
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned CONT      = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       din,
  input  logic       din_valid,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [2:0] sel,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] dout_q, dout_d;
  logic       dv_q, dv_d;
  logic       ovr_q, ovr_d;

  logic [2:0] lane;
  logic [2:0] lane0;
  logic [7:0] byte_new;

  always_comb begin
    lane     = (LSB_FIRST != 0) ? sel_q : (3'd7 - sel_q);
    lane0    = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
    byte_new = shadow_q;
    byte_new[lane] = din;
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    dv_d     = dv_q;
    ovr_d    = 1'b0;

    // Consumption; a simultaneous completion below may re-set dv_d.
    if (dv_q && dout_ready) begin
      dv_d = 1'b0;
    end

    if (start) begin
      // Restart discards any partial frame; never produces output.
      state_d  = StCollect;
      shadow_d = 8'h00;
      sel_d    = 3'd0;
      if (din_valid) begin
        shadow_d[lane0] = din;
        sel_d           = 3'd1;
      end
    end else if (state_q == StCollect && din_valid) begin
      shadow_d = byte_new;
      sel_d    = sel_q + 3'd1;
      if (sel_q == 3'd7) begin
        if (!dv_q || dout_ready) begin
          dout_d = byte_new;
          dv_d   = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
        if (CONT == 0) begin
          state_d = StIdle;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= 3'd0;
      shadow_q <= 8'h00;
      dout_q   <= 8'h00;
      dv_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign sel        = sel_q;
  assign busy       = (state_q == StCollect);
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_demux8_collect.sv
// Bench for demux8_collect: four instances covering every LSB_FIRST/CONT combination,
// directed scenarios against known bytes plus a randomized run against a frame-level model.
module tb_demux8_collect;

  // Config index i: LSB_FIRST = i % 2, CONT = i / 2.
  logic clk = 1'b0;
  logic rst_n, start, din, din_valid, dout_ready;
  logic [7:0] dout_w [4];
  logic       dv_w   [4];
  logic [2:0] sel_w  [4];
  logic       busy_w [4];
  logic       ovr_w  [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    demux8_collect #(
      .LSB_FIRST(g % 2),
      .CONT     (g / 2)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .din       (din),
      .din_valid (din_valid),
      .dout      (dout_w[g]),
      .dout_valid(dv_w[g]),
      .dout_ready(dout_ready),
      .sel       (sel_w[g]),
      .busy      (busy_w[g]),
      .overrun   (ovr_w[g])
    );
  end

  int nvec = 0;
  int nerr = 0;

  // Frame-level reference: bits kept in arrival order, byte assembled arithmetically.
  bit         m_busy [4];
  int         m_n    [4];
  bit         m_bits [4][8];
  logic [7:0] m_dout [4];
  bit         m_dv   [4];
  bit         m_ovr  [4];

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 0; m_n[i] = 0; m_dout[i] = 8'h00; m_dv[i] = 0; m_ovr[i] = 0;
      for (int k = 0; k < 8; k++) m_bits[i][k] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 4; i++) begin
      int  val;
      bit  consume;
      m_ovr[i] = 0;
      consume  = m_dv[i] && dout_ready;
      if (start) begin
        m_busy[i] = 1;
        m_n[i]    = 0;
        if (din_valid) begin
          m_bits[i][0] = din;
          m_n[i]       = 1;
        end
      end else if (m_busy[i] && din_valid) begin
        m_bits[i][m_n[i]] = din;
        m_n[i]++;
        if (m_n[i] == 8) begin
          val = 0;
          for (int k = 0; k < 8; k++)
            val += int'(m_bits[i][k]) * ((i % 2 == 1) ? (1 << k) : (1 << (7 - k)));
          m_n[i] = 0;
          if (!m_dv[i] || dout_ready) begin
            m_dout[i] = val[7:0];
            m_dv[i]   = 1;
            consume   = 0;
          end else begin
            m_ovr[i] = 1;
          end
          if (i / 2 == 0) m_busy[i] = 0;
        end
      end
      if (consume) m_dv[i] = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic send_bit(input bit s, input bit d);
    start = s; din = d; din_valid = 1'b1;
    tick();
    start = 1'b0; din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    model_reset();
    #12;
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (dout_w[i] !== 8'h00 || dv_w[i] !== 1'b0 || sel_w[i] !== 3'd0 ||
          busy_w[i] !== 1'b0 || ovr_w[i] !== 1'b0) begin
        nerr++;
        $display("FAIL reset cfg%0d: dout=%h dv=%b sel=%0d busy=%b ovr=%b, want all 0",
                 i, dout_w[i], dv_w[i], sel_w[i], busy_w[i], ovr_w[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    din = 1'b1; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    nvec++;
    if (busy_w[1] !== 1'b0 || sel_w[1] !== 3'd0) begin
      nerr++;
      $display("FAIL idle_ignore: busy=%b sel=%0d, want 0 0", busy_w[1], sel_w[1]);
    end
  endtask

  task automatic test_byte();
    bit b [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    send_bit(1'b1, b[0]);
    nvec++;
    if (sel_w[1] !== 3'd1 || busy_w[1] !== 1'b1) begin
      nerr++;
      $display("FAIL start_capture: sel=%0d busy=%b, want 1 1", sel_w[1], busy_w[1]);
    end
    for (int k = 1; k < 8; k++) send_bit(1'b0, b[k]);
    nvec++;
    if (dout_w[1] !== 8'h4D || dv_w[1] !== 1'b1 || busy_w[1] !== 1'b0 || sel_w[1] !== 3'd0) begin
      nerr++;
      $display("FAIL lsb_byte: dout=%h dv=%b busy=%b sel=%0d, want 4d 1 0 0",
               dout_w[1], dv_w[1], busy_w[1], sel_w[1]);
    end
    nvec++;
    if (dout_w[0] !== 8'hB2 || dv_w[0] !== 1'b1) begin
      nerr++;
      $display("FAIL msb_byte: dout=%h dv=%b, want b2 1", dout_w[0], dv_w[0]);
    end
    nvec++;
    if (busy_w[3] !== 1'b1 || dout_w[2] !== 8'hB2) begin
      nerr++;
      $display("FAIL cont_byte: busy=%b dout=%h, want 1 b2", busy_w[3], dout_w[2]);
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    nvec++;
    if (dv_w[1] !== 1'b0 || dout_w[1] !== 8'h4D) begin
      nerr++;
      $display("FAIL consume: dv=%b dout=%h, want 0 4d", dv_w[1], dout_w[1]);
    end
  endtask

  task automatic test_overrun();
    send_bit(1'b1, 1'b1);
    for (int k = 1; k < 8; k++) send_bit(1'b0, 1'b1);
    nvec++;
    if (dout_w[3] !== 8'hFF || dv_w[3] !== 1'b1 || ovr_w[3] !== 1'b0) begin
      nerr++;
      $display("FAIL ovr_first: dout=%h dv=%b ovr=%b, want ff 1 0", dout_w[3], dv_w[3], ovr_w[3]);
    end
    for (int k = 0; k < 7; k++) send_bit(1'b0, 1'b0);
    nvec++;
    if (ovr_w[3] !== 1'b0) begin
      nerr++;
      $display("FAIL ovr_early: ovr=%b, want 0", ovr_w[3]);
    end
    send_bit(1'b0, 1'b0);
    nvec++;
    if (ovr_w[3] !== 1'b1 || dout_w[3] !== 8'hFF || busy_w[3] !== 1'b1 || dv_w[3] !== 1'b1) begin
      nerr++;
      $display("FAIL ovr_pulse: ovr=%b dout=%h busy=%b dv=%b, want 1 ff 1 1",
               ovr_w[3], dout_w[3], busy_w[3], dv_w[3]);
    end
    tick();
    nvec++;
    if (ovr_w[3] !== 1'b0) begin
      nerr++;
      $display("FAIL ovr_width: ovr=%b, want 0", ovr_w[3]);
    end
  endtask

  task automatic test_ready_on_complete();
    logic [7:0] a = 8'hA5;
    logic [7:0] c = 8'h3C;
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    for (int k = 0; k < 8; k++) send_bit(k == 0, a[k]);
    nvec++;
    if (dout_w[3] !== 8'hA5 || dv_w[3] !== 1'b1) begin
      nerr++;
      $display("FAIL hold_a5: dout=%h dv=%b, want a5 1", dout_w[3], dv_w[3]);
    end
    for (int k = 0; k < 8; k++) begin
      dout_ready = (k == 7);
      send_bit(1'b0, c[k]);
    end
    dout_ready = 1'b0;
    nvec++;
    if (dout_w[3] !== 8'h3C || dv_w[3] !== 1'b1 || ovr_w[3] !== 1'b0) begin
      nerr++;
      $display("FAIL ready_complete: dout=%h dv=%b ovr=%b, want 3c 1 0",
               dout_w[3], dv_w[3], ovr_w[3]);
    end
  endtask

  task automatic test_restart();
    logic [7:0] v = 8'h81;
    bit         ovr_seen = 0;
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_bit(k == 0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      send_bit(k == 0, v[k]);
      if (ovr_w[1] === 1'b1) ovr_seen = 1;
      if (k < 7 && dv_w[1] !== 1'b0) ovr_seen = 1;
    end
    nvec++;
    if (dout_w[1] !== 8'h81 || dv_w[1] !== 1'b1 || ovr_seen) begin
      nerr++;
      $display("FAIL restart: dout=%h dv=%b spurious=%b, want 81 1 0",
               dout_w[1], dv_w[1], ovr_seen);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) send_bit(k == 0, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (dout_w[i] !== 8'h00 || dv_w[i] !== 1'b0 || sel_w[i] !== 3'd0 ||
          busy_w[i] !== 1'b0 || ovr_w[i] !== 1'b0) begin
        nerr++;
        $display("FAIL reset_mid cfg%0d: dout=%h dv=%b sel=%0d busy=%b ovr=%b, want all 0",
                 i, dout_w[i], dv_w[i], sel_w[i], busy_w[i], ovr_w[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) send_bit(1'b0, 1'b1);
    nvec++;
    if (sel_w[1] !== 3'd0 || busy_w[1] !== 1'b0 || dv_w[1] !== 1'b0) begin
      nerr++;
      $display("FAIL post_reset: sel=%0d busy=%b dv=%b, want 0 0 0",
               sel_w[1], busy_w[1], dv_w[1]);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 800; cyc++) begin
      start      = ($urandom_range(0, 15) == 0);
      din        = 1'($urandom);
      din_valid  = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 2) == 0);
      tick();
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (dout_w[i] !== m_dout[i] || dv_w[i] !== m_dv[i] || sel_w[i] !== 3'(m_n[i]) ||
            busy_w[i] !== m_busy[i] || ovr_w[i] !== m_ovr[i]) begin
          nerr++;
          $display("FAIL rand cfg%0d cyc%0d: got dout=%h dv=%b sel=%0d busy=%b ovr=%b, want dout=%h dv=%b sel=%0d busy=%b ovr=%b",
                   i, cyc, dout_w[i], dv_w[i], sel_w[i], busy_w[i], ovr_w[i],
                   m_dout[i], m_dv[i], m_n[i], m_busy[i], m_ovr[i]);
        end
      end
    end
    start = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte();
    test_overrun();
    test_ready_on_complete();
    test_restart();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
